// File: rtl/cpu_pkg.sv
// Shared CPU definitions: pcsrc encodings, opcode map and fetch FSM states.
package cpu_pkg;

    localparam logic [1:0] PCSRC_SEQ = 2'd0;
    localparam logic [1:0] PCSRC_IMM = 2'd1;
    localparam logic [1:0] PCSRC_REG = 2'd2;

    localparam logic [3:0] OP_JAL  = 4'b0000;
    localparam logic [3:0] OP_JALR = 4'b0001;
    localparam logic [3:0] OP_BEQ  = 4'b0010;
    localparam logic [3:0] OP_BNE  = 4'b0011;
    localparam logic [3:0] OP_BLT  = 4'b0100;
    localparam logic [3:0] OP_BGE  = 4'b0101;
    localparam logic [3:0] OP_LW   = 4'b0110;
    localparam logic [3:0] OP_SW   = 4'b0111;
    localparam logic [3:0] OP_ADD  = 4'b1000;
    localparam logic [3:0] OP_SUB  = 4'b1001;
    localparam logic [3:0] OP_AND  = 4'b1010;
    localparam logic [3:0] OP_OR   = 4'b1011;
    localparam logic [3:0] OP_XOR  = 4'b1100;
    localparam logic [3:0] OP_SLT  = 4'b1101;
    localparam logic [3:0] OP_ADDI = 4'b1110;
    localparam logic [3:0] OP_ORI  = 4'b1111;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_FLUSH = 2'd2
    } fetch_state_e;

    // Only the two target-forming pcsrc values move the PC; 0 and 3 are sequential.
    function automatic logic is_redirect(input logic valid, input logic [1:0] src);
        return valid && ((src == PCSRC_IMM) || (src == PCSRC_REG));
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO with single-cycle flush; push at full is accepted when a pop
// happens in the same cycle.
module fetch_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_empty,
    output logic             o_full
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    // Storage needs no reset: entries are only visible through the count.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// CPU fetch front end: PC, imem req/ack FSM, prefetch FIFO and redirect handling.
// Optional FETCH_PERF_CNT_EN adds saturating fetch/flush counters.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W     = 8,
    parameter int                INSTR_W    = 16,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [3:0]         opcode,
    input  logic               redirect_valid,
    input  logic [1:0]         pcsrc,
    input  logic [ADDR_W-1:0]  redirect_base,
    input  logic [ADDR_W-1:0]  imm_sext,
    input  logic [ADDR_W-1:0]  reg_target,
    output logic [15:0]        perf_fetched,
    output logic [15:0]        perf_flushes
);

    fetch_state_e        r_state;
    fetch_state_e        w_next_state;
    logic [ADDR_W-1:0]   r_fetch_pc;
    logic [ADDR_W-1:0]   r_req_addr;
    logic                w_redirect;
    logic [ADDR_W-1:0]   w_target;
    logic                w_req;
    logic                w_issue;
    logic                w_push;
    logic                w_fifo_empty;
    logic                w_fifo_full;
    logic [INSTR_W+ADDR_W-1:0] w_head;

    assign w_redirect = is_redirect(redirect_valid, pcsrc);
    assign w_target   = (pcsrc == PCSRC_REG) ? redirect_base + reg_target
                                             : redirect_base + imm_sext;

    always_comb begin
        w_next_state = r_state;
        w_req        = 1'b0;
        w_issue      = 1'b0;
        w_push       = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (!w_fifo_full && !w_redirect) begin
                    w_req        = 1'b1;
                    w_issue      = 1'b1;
                    w_next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                w_req = 1'b1;
                if (imem_ack) begin
                    w_push       = !w_redirect;
                    w_next_state = S_FETCH;
                end else if (w_redirect) begin
                    w_next_state = S_FLUSH;
                end
            end
            // Outstanding request to the old path must complete before refetching.
            S_FLUSH: begin
                w_req = 1'b1;
                if (imem_ack) w_next_state = S_FETCH;
            end
            default: w_next_state = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_FETCH;
            r_fetch_pc <= RESET_PC;
            r_req_addr <= RESET_PC;
        end else begin
            r_state <= w_next_state;
            if (w_issue) r_req_addr <= r_fetch_pc;
            if (w_redirect)  r_fetch_pc <= w_target;
            else if (w_push) r_fetch_pc <= r_fetch_pc + 1'b1;
        end
    end

    assign imem_req  = w_req && !rst;
    assign imem_addr = (r_state == S_FETCH) ? r_fetch_pc : r_req_addr;

    fetch_fifo #(
        .WIDTH (INSTR_W + ADDR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (w_redirect),
        .i_push  (w_push),
        .i_data  ({imem_rdata, r_fetch_pc}),
        .i_pop   (out_ready),
        .o_head  (w_head),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );

    assign out_valid = !w_fifo_empty;
    assign out_instr = out_valid ? w_head[INSTR_W+ADDR_W-1:ADDR_W] : '0;
    assign out_pc    = out_valid ? w_head[ADDR_W-1:0] : '0;
    assign opcode    = out_instr[INSTR_W-1:INSTR_W-4];

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] r_perf_fetched;
    logic [15:0] r_perf_flushes;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_fetched <= '0;
            r_perf_flushes <= '0;
        end else begin
            if (w_push && (r_perf_fetched != 16'hFFFF))     r_perf_fetched <= r_perf_fetched + 1'b1;
            if (w_redirect && (r_perf_flushes != 16'hFFFF)) r_perf_flushes <= r_perf_flushes + 1'b1;
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_flushes = r_perf_flushes;
`else
    assign perf_fetched = '0;
    assign perf_flushes = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: imem responder model with variable ack latency and
// a scoreboard of expected {pc, instr} pairs checked as the decode side pops.
module tb_instr_fetch_unit;

    localparam int AW = 8;
    localparam int IW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [IW-1:0] imem_rdata;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_instr;
    logic [AW-1:0] out_pc;
    logic [3:0]    opcode;
    logic          redirect_valid;
    logic [1:0]    pcsrc;
    logic [AW-1:0] redirect_base;
    logic [AW-1:0] imm_sext;
    logic [AW-1:0] reg_target;
    logic [15:0]   perf_fetched;
    logic [15:0]   perf_flushes;

    instr_fetch_unit #(.ADDR_W(AW), .INSTR_W(IW), .RESET_PC(8'h00), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
        .opcode(opcode),
        .redirect_valid(redirect_valid), .pcsrc(pcsrc), .redirect_base(redirect_base),
        .imm_sext(imm_sext), .reg_target(reg_target),
        .perf_fetched(perf_fetched), .perf_flushes(perf_flushes)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [IW-1:0] instr;
    } exp_t;

    exp_t          sb[$];
    int            pop_cyc[$];
    int            checks = 0;
    int            errors = 0;
    int            lat = 1;
    int            n_reqs = 0;
    int            cyc = 0;
    bit            rsp_busy = 1'b0;
    int            rsp_wcnt = 0;
    logic [AW-1:0] rsp_addr = '0;

    function automatic logic [IW-1:0] mem(input logic [AW-1:0] a);
        return {a[3:0] ^ 4'h9, a[3:0], a};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Instruction memory: latches a request, answers after 'lat' cycles with a one-cycle ack.
    initial begin
        imem_ack   = 1'b0;
        imem_rdata = '0;
        forever begin
            @(negedge clk);
            imem_ack = 1'b0;
            if (rsp_busy) begin
                if (imem_req) chk("addr_hold", 32'(imem_addr), 32'(rsp_addr));
                if (rsp_wcnt <= 1) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem(rsp_addr);
                    rsp_busy   = 1'b0;
                end else begin
                    rsp_wcnt--;
                end
            end else if (imem_req) begin
                rsp_busy = 1'b1;
                rsp_addr = imem_addr;
                rsp_wcnt = lat;
                n_reqs++;
            end
        end
    end

    // Decode-side monitor: every accepted head entry is compared with the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (out_valid && out_ready && sb.size() > 0) begin
                e = sb.pop_front();
                chk("out_pc", 32'(out_pc), 32'(e.pc));
                chk("out_instr", 32'(out_instr), 32'(e.instr));
                chk("opcode", 32'(opcode), 32'(e.instr[IW-1:IW-4]));
                pop_cyc.push_back(cyc);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        tick(6);
        rst = 1'b0;
    endtask

    task automatic expect_pcs(input logic [AW-1:0] start, input int n);
        for (int i = 0; i < n; i++) begin
            logic [AW-1:0] p;
            p = start + AW'(i);
            sb.push_back({p, mem(p)});
        end
    endtask

    task automatic wait_drain(input int maxc);
        int c;
        c = 0;
        while (sb.size() > 0 && c < maxc) begin
            tick();
            c++;
        end
        chk("drain_left", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic wait_req(input int maxc);
        int c;
        c = 0;
        while (!imem_req && c < maxc) begin
            tick();
            c++;
        end
        chk("req_seen", 32'(imem_req), 32'd1);
    endtask

    task automatic redirect(input logic [1:0] src, input logic [AW-1:0] base,
                            input logic [AW-1:0] imm, input logic [AW-1:0] rg);
        redirect_valid = 1'b1;
        pcsrc          = src;
        redirect_base  = base;
        imm_sext       = imm;
        reg_target     = rg;
        tick();
        redirect_valid = 1'b0;
        pcsrc          = 2'd0;
    endtask

    initial begin
        int n0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        pcsrc          = 2'd0;
        redirect_base  = '0;
        imm_sext       = '0;
        reg_target     = '0;

        // Reset state
        rst = 1'b1;
        tick(3);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'h00);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_instr", 32'(out_instr), 32'd0);
        chk("rst_pc", 32'(out_pc), 32'd0);
        chk("rst_opcode", 32'(opcode), 32'd0);
        chk("rst_perf_f", 32'(perf_fetched), 32'd0);
        chk("rst_perf_r", 32'(perf_flushes), 32'd0);

        // Sequential stream; pcsrc 3 and 0 redirects must be ignored
        lat = 1;
        do_reset();
        pop_cyc.delete();
        expect_pcs(8'h00, 6);
        out_ready = 1'b1;
        tick(3);
        redirect(2'd3, 8'h40, 8'h10, 8'h10);
        redirect(2'd0, 8'h40, 8'h10, 8'h10);
        wait_drain(60);
        if (pop_cyc.size() >= 6) chk("throughput", 32'(pop_cyc[5] - pop_cyc[4]), 32'd2);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetched_min", 32'(perf_fetched >= 16'd6), 32'd1);
        chk("perf_flushes_zero", 32'(perf_flushes), 32'd0);
`endif

        // Backpressure: two entries fill the buffer, then fetch stalls
        out_ready = 1'b0;
        do_reset();
        n0 = n_reqs;
        tick(20);
        chk("bp_reqs", 32'(n_reqs - n0), 32'd2);
        chk("bp_req_idle", 32'(imem_req), 32'd0);
        chk("bp_valid", 32'(out_valid), 32'd1);
        chk("bp_head_pc", 32'(out_pc), 32'h00);
        expect_pcs(8'h00, 5);
        out_ready = 1'b1;
        wait_drain(60);

        // Immediate redirect with full buffer: 0x10 + 0xFC -> 0x0C
        out_ready = 1'b0;
        do_reset();
        tick(20);
        redirect(2'd1, 8'h10, 8'hFC, 8'h77);
        chk("redir_flush_valid", 32'(out_valid), 32'd0);
        expect_pcs(8'h0C, 3);
        out_ready = 1'b1;
        wait_drain(60);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_flushes_one", 32'(perf_flushes), 32'd1);
`endif

        // Register redirect while waiting on a slow ack: stale data dropped, then 0x25
        lat = 3;
        out_ready = 1'b1;
        do_reset();
        wait_req(10);
        tick();
        expect_pcs(8'h25, 3);
        redirect(2'd2, 8'h20, 8'h33, 8'h05);
        chk("flush_req_held", 32'(imem_req), 32'd1);
        chk("flush_addr_held", 32'(imem_addr), 32'h00);
        chk("flush_valid", 32'(out_valid), 32'd0);
        wait_drain(80);

        // PC wrap 0xFF -> 0x00
        lat = 1;
        do_reset();
        tick(2);
        redirect(2'd1, 8'hFE, 8'h01, 8'h00);
        expect_pcs(8'hFF, 3);
        wait_drain(60);

        // Reset during an outstanding request; late ack lands while in reset
        lat = 3;
        do_reset();
        wait_req(10);
        tick();
        rst = 1'b1;
        tick(6);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_req", 32'(imem_req), 32'd0);
        chk("midrst_perf_f", 32'(perf_fetched), 32'd0);
        chk("midrst_perf_r", 32'(perf_flushes), 32'd0);
        rst = 1'b0;
        #1;
        chk("midrst_next_req", 32'(imem_req), 32'd1);
        chk("midrst_next_addr", 32'(imem_addr), 32'h00);
        expect_pcs(8'h00, 2);
        wait_drain(60);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
